// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address. Writes land in dout, reads return din.
// SDA is open-drain (0 or Z only), and SCL is sampled but never stretched.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR                = 7'h48,
    parameter int         MAX_BYTES_PER_TRANSACTION = 3
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               scl_pin,
    inout  wire                                                sda_pin,
    input  logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0]          din,
    output logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0]          dout,
    output logic [$clog2(MAX_BYTES_PER_TRANSACTION+1)-1:0]     rx_bytes_num,
    output logic                                               rd_nwr,
    output logic                                               transaction_done
);

    localparam int               IDX_W   = $clog2(MAX_BYTES_PER_TRANSACTION + 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_BYTES_PER_TRANSACTION);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t r_state, w_state_nxt;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    logic [7:0]                                       r_shift;
    logic [3:0]                                       r_bit_cnt;
    logic [IDX_W-1:0]                                 r_idx;
    logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0]        r_dout;
    logic [IDX_W-1:0]                                 r_rx;
    logic                                             r_rd_nwr;
    logic                                             r_matched;
    logic                                             r_sda_low;
    logic                                             r_done;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
    logic       w_addr_match, w_idx_ok, w_byte_end;
    logic [7:0] w_rd_byte;
    logic       w_sda_low_nxt, w_done_nxt;

    // The third flop of each chain holds the previous synchronised value for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments, so each stage samples the value from before the edge.
            r_scl_s1 <= scl_pin;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_pin;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise   = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall   = ~r_scl_s2 & r_scl_d;
    assign w_start      = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop       = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_sda        = r_sda_s2;
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);
    assign w_idx_ok     = (r_idx < IDX_MAX);
    assign w_rd_byte    = w_idx_ok ? din[r_idx] : 8'hFF;
    assign w_byte_end   = (r_bit_cnt == 4'd8);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: the default comes first so that every path assigns, and no latch is inferred.
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ADDR;
        end else if (w_stop && r_state != IDLE) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                ADDR:     if (w_scl_fall && w_byte_end) w_state_nxt = w_addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (w_scl_fall) w_state_nxt = r_rd_nwr ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (w_scl_fall && w_byte_end) w_state_nxt = WR_ACK;
                WR_ACK:   if (w_scl_fall) w_state_nxt = WR_BYTE;
                RD_BYTE:  if (w_scl_fall && w_byte_end) w_state_nxt = RD_ACK;
                RD_ACK: begin
                    if (w_scl_rise && w_sda) w_state_nxt = IGNORE;
                    else if (w_scl_fall)     w_state_nxt = RD_BYTE;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // The SDA drive changes only on SCL falls, except when START or STOP releases it.
    always_comb begin
        w_sda_low_nxt = r_sda_low;
        w_done_nxt    = 1'b0;
        if (w_start) begin
            w_sda_low_nxt = 1'b0;
        end else if (w_stop) begin
            w_sda_low_nxt = 1'b0;
            w_done_nxt    = (r_state != IDLE) && r_matched;
        end else if (w_scl_fall) begin
            case (r_state)
                ADDR:     if (w_byte_end) w_sda_low_nxt = w_addr_match;
                ADDR_ACK: w_sda_low_nxt = r_rd_nwr & ~w_rd_byte[7];
                WR_BYTE:  if (w_byte_end) w_sda_low_nxt = w_idx_ok;
                RD_BYTE:  w_sda_low_nxt = w_byte_end ? 1'b0 : ~r_shift[6];
                RD_ACK:   w_sda_low_nxt = ~w_rd_byte[7];
                default:  w_sda_low_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 4'd0;
            r_idx     <= '0;
            // NOTE: the dout bank is reset with the control state, so it reads back as zeros after reset.
            r_dout    <= '0;
            r_rx      <= '0;
            r_rd_nwr  <= 1'b0;
            r_matched <= 1'b0;
            r_sda_low <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_sda_low <= w_sda_low_nxt;
            r_done    <= w_done_nxt;
            if (w_start) begin
                r_bit_cnt <= 4'd0;
                r_idx     <= '0;
                r_matched <= 1'b0;
            end else if (w_stop) begin
                r_bit_cnt <= 4'd0;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_scl_rise && !w_byte_end) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && w_byte_end && w_addr_match) begin
                            r_matched <= 1'b1;
                            r_rd_nwr  <= r_shift[0];
                            if (!r_shift[0]) r_rx <= '0;
                        end
                    end
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 4'd0;
                            r_shift   <= w_rd_byte;
                        end
                    end
                    WR_BYTE: begin
                        if (w_scl_rise && !w_byte_end) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && w_byte_end && w_idx_ok) begin
                            r_dout[r_idx] <= r_shift;
                            r_idx         <= r_idx + IDX_ONE;
                            r_rx          <= r_idx + IDX_ONE;
                        end
                    end
                    WR_ACK: begin
                        if (w_scl_fall) r_bit_cnt <= 4'd0;
                    end
                    RD_BYTE: begin
                        if (w_scl_rise && !w_byte_end) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && !w_byte_end) begin
                            r_shift <= {r_shift[6:0], 1'b1};
                        end
                    end
                    RD_ACK: begin
                        // The index steps on the master's ACK, and the next byte is captured on the following fall.
                        if (w_scl_rise && !w_sda && w_idx_ok) begin
                            r_idx <= r_idx + IDX_ONE;
                        end else if (w_scl_fall) begin
                            r_bit_cnt <= 4'd0;
                            r_shift   <= w_rd_byte;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_pin          = r_sda_low ? 1'b0 : 1'bz;
    assign dout             = r_dout;
    assign rx_bytes_num     = r_rx;
    assign rd_nwr           = r_rd_nwr;
    assign transaction_done = r_done;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master plus a transaction-level model
// that tracks the expected ACKs, read data, dout, rx_bytes_num, rd_nwr and done pulses.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int         MAXB = 3;
    localparam logic [6:0] SADR = 7'h48;
    localparam int         Q    = 6;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  scl = 1'b1;
    logic                  m_sda_low = 1'b0;
    logic                  m_cond = 1'b0;
    wire                   sda;
    logic [MAXB-1:0][7:0]  din;
    logic [MAXB-1:0][7:0]  dout;
    logic [1:0]            rx_bytes_num;
    logic                  rd_nwr;
    logic                  transaction_done;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(SADR), .MAX_BYTES_PER_TRANSACTION(MAXB)) dut (
        .clk              (clk),
        .reset            (reset),
        .scl_pin          (scl),
        .sda_pin          (sda),
        .din              (din),
        .dout             (dout),
        .rx_bytes_num     (rx_bytes_num),
        .rd_nwr           (rd_nwr),
        .transaction_done (transaction_done)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0, done_wide = 0, glitch_cnt = 0, dut_low_cnt = 0;
    logic prev_done = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;

    // Bus monitor. SDA may change while SCL is high only during START, STOP or reset.
    always @(negedge clk) begin
        if (transaction_done) done_cnt++;
        if (transaction_done && prev_done) done_wide++;
        if (scl && prev_scl && (sda != prev_sda) && !m_cond) glitch_cnt++;
        if (!m_sda_low && !sda) dut_low_cnt++;
        prev_done = transaction_done;
        prev_scl  = scl;
        prev_sda  = sda;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_dout [MAXB];
    int         exp_rx;
    bit         exp_rdnwr;
    bit         m_matched;
    int         m_idx;
    int         done_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quarter();
        repeat (Q) @(posedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < MAXB; k++) exp_dout[k] = 8'h00;
        exp_rx    = 0;
        exp_rdnwr = 1'b0;
        m_matched = 1'b0;
        m_idx     = 0;
    endtask

    task automatic rand_din();
        for (int k = 0; k < MAXB; k++) din[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic i2c_start();
        m_cond = 1'b1;
        m_sda_low = 1'b0; quarter();
        scl = 1'b1;       quarter();
        m_sda_low = 1'b1; quarter();
        scl = 1'b0;       quarter();
        m_cond = 1'b0;
    endtask

    task automatic i2c_stop();
        m_cond = 1'b1;
        m_sda_low = 1'b1; quarter();
        scl = 1'b1;       quarter();
        m_sda_low = 1'b0; quarter();
        quarter();
        m_cond = 1'b0;
    endtask

    task automatic clk_bit(input bit b, output bit s);
        m_sda_low = !b; quarter();
        scl = 1'b1;     quarter();
        s = sda;        quarter();
        scl = 1'b0;     quarter();
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, s);
        ack = !s;
    endtask

    task automatic read_byte(input bit mack, input bit scramble, output logic [7:0] d);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
            if (scramble && i == 4) rand_din();
        end
        clk_bit(!mack, s);
    endtask

    task automatic do_addr(input logic [6:0] a, input bit rw);
        bit ack;
        i2c_start();
        m_matched = (a == SADR);
        m_idx = 0;
        write_byte({a, rw}, ack);
        check("addr_ack", ack, m_matched);
        if (m_matched) begin
            exp_rdnwr = rw;
            if (!rw) exp_rx = 0;
        end
    endtask

    task automatic do_write(input logic [7:0] d);
        bit ack, exp_ack;
        write_byte(d, ack);
        exp_ack = m_matched && (m_idx < MAXB);
        check("wr_ack", ack, exp_ack);
        if (exp_ack) begin
            exp_dout[m_idx] = d;
            m_idx++;
            exp_rx = m_idx;
        end
    endtask

    task automatic do_read(input int n, input bit scramble);
        for (int i = 0; i < n; i++) begin
            logic [7:0] e, g;
            e = (m_matched && i < MAXB) ? din[i] : 8'hFF;
            read_byte(i != n - 1, scramble, g);
            check("rd_byte", g, e);
        end
        check("rd_release", sda, 1'b1);
    endtask

    task automatic end_xfer();
        i2c_stop();
        repeat (4) @(posedge clk);
        check("done_cnt", done_cnt - done_base, m_matched);
        for (int k = 0; k < MAXB; k++) check("dout", dout[k], exp_dout[k]);
        check("rx_bytes_num", rx_bytes_num, exp_rx);
        check("rd_nwr", rd_nwr, exp_rdnwr);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sda"}, sda, 1'b1);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_rx"}, rx_bytes_num, 0);
        check({tag, "_rdnwr"}, rd_nwr, 0);
        check({tag, "_done"}, transaction_done, 0);
    endtask

    initial begin
        bit s;
        int low_base;
        rand_din();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b1;
        quarter();

        // Write three bytes.
        done_base = done_cnt;
        do_addr(SADR, 1'b0);
        do_write(8'h01); do_write(8'h42); do_write(8'hA3);
        end_xfer();

        // Address 0x49 does not match.
        done_base = done_cnt;
        low_base  = dut_low_cnt;
        do_addr(7'h49, 1'b0);
        do_write(8'h55); do_write(8'h66);
        end_xfer();
        check("nomatch_sda_low", dut_low_cnt - low_base, 0);

        // Read two bytes. The master ACKs the first byte and NACKs the second.
        din = {8'h00, 8'h29, 8'hA0};
        done_base = done_cnt;
        do_addr(SADR, 1'b1);
        do_read(2, 1'b0);
        end_xfer();

        // Four bytes written against a three-byte buffer.
        done_base = done_cnt;
        do_addr(SADR, 1'b0);
        do_write(8'h11); do_write(8'h22); do_write(8'h33); do_write(8'h44);
        end_xfer();

        // Write, then a repeated START and a read.
        rand_din();
        done_base = done_cnt;
        do_addr(SADR, 1'b0);
        do_write(8'h5A);
        do_addr(SADR, 1'b1);
        do_read(1, 1'b0);
        end_xfer();

        // Reset during the 5th bit of a read byte whose bits are all 0.
        din[0] = 8'h00;
        done_base = done_cnt;
        do_addr(SADR, 1'b1);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
        m_sda_low = 1'b0; quarter();
        scl = 1'b1;       quarter();
        check("rst_pre_drive", sda, 1'b0);
        m_cond = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        quarter();
        scl = 1'b0;
        quarter();
        m_cond = 1'b0;
        for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
        end_xfer();
        done_base = done_cnt;
        do_addr(SADR, 1'b0);
        do_write(8'hC3); do_write(8'h3C);
        end_xfer();

        // Random transactions.
        for (int t = 0; t < 12; t++) begin
            logic [6:0] a;
            bit         rw;
            int         n;
            a  = ($urandom_range(0, 3) == 0) ? (SADR ^ 7'($urandom_range(1, 127))) : SADR;
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 5);
            rand_din();
            done_base = done_cnt;
            do_addr(a, rw);
            if (rw) begin
                do_read(n, 1'($urandom_range(0, 1)));
            end else begin
                for (int k = 0; k < n; k++) do_write(8'($urandom_range(0, 255)));
            end
            end_xfer();
        end

        check("done_width", done_wide, 0);
        check("sda_scl_high_change", glitch_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
